// File: rtl/pfpu32_pkg.sv
// Shared pfpu32 definitions: field widths, the unpacked-operand record and the
// binary32 decode used by the unpack, f2i and i2f front ends.
package pfpu32_pkg;

  localparam int         EXP_W    = 10;
  localparam int         FRACT_W  = 24;
  localparam int         NLZ_W    = 5;
  localparam logic [7:0] EXP8_MAX = 8'hFF;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_DNRM,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } pfpu32_class_t;

  typedef struct packed {
    logic               sign;
    logic [EXP_W-1:0]   exp10;
    logic [FRACT_W-1:0] fract24;
    logic               snan;
    logic               qnan;
    logic               inf;
    logic               zero;
    logic [NLZ_W-1:0]   nlz;
    logic [EXP_W-1:0]   exp10n;
    logic [FRACT_W-1:0] fract24n;
  } pfpu32_unpacked_t;

  function automatic pfpu32_class_t pfpu32_classify(input logic [31:0] op);
    pfpu32_class_t cls;
    logic [7:0]    e8;
    logic [22:0]   f23;
    e8  = op[30:23];
    f23 = op[22:0];
    if (e8 == 8'h00)
      cls = (f23 == '0) ? CLS_ZERO : CLS_DNRM;
    else if (e8 == EXP8_MAX) begin
      if (f23 == '0)
        cls = CLS_INF;
      else if (f23[22])
        cls = CLS_QNAN;
      else
        cls = CLS_SNAN;
    end else
      cls = CLS_NORM;
    return cls;
  endfunction

  // Normalized fields default to the raw ones; the unpack pipe overwrites them.
  function automatic pfpu32_unpacked_t pfpu32_decode(input logic [31:0] op);
    pfpu32_unpacked_t u;
    pfpu32_class_t    cls;
    cls        = pfpu32_classify(op);
    u          = '0;
    u.sign     = op[31];
    u.exp10    = {2'b00, op[30:23]} + {{(EXP_W-1){1'b0}}, (cls == CLS_DNRM)};
    u.fract24  = {(op[30:23] != 8'h00), op[22:0]};
    u.snan     = (cls == CLS_SNAN);
    u.qnan     = (cls == CLS_QNAN);
    u.inf      = (cls == CLS_INF);
    u.zero     = (cls == CLS_ZERO);
    u.exp10n   = u.exp10;
    u.fract24n = u.fract24;
    return u;
  endfunction

endpackage

// File: rtl/pfpu32_nlz24.sv
// 24-bit leading-zero counter; an all-zero input reports 0.
module pfpu32_nlz24
  import pfpu32_pkg::*;
(
  input  logic [FRACT_W-1:0] fract24,
  output logic [NLZ_W-1:0]   nlz
);

  // Scanning upward lets the most significant set bit win.
  always_comb begin
    nlz = '0;
    for (int i = 0; i < FRACT_W; i++) begin
      if (fract24[i])
        nlz = NLZ_W'(FRACT_W - 1 - i);
    end
  end

endmodule

// File: rtl/pfpu32_unpack.sv
// Two-stage binary32 operand unpacker: stage 1 classifies, stage 2 normalizes
// denormals for the mul/div units. Valid/ready on both sides.
module pfpu32_unpack
  import pfpu32_pkg::*;
#(
  parameter int TAG_W   = 8,
  parameter int NORM_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [31:0]        opa_i,
  input  logic [31:0]        opb_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [TAG_W-1:0]   tag_o,
  output logic               signa_o,
  output logic               signb_o,
  output logic [EXP_W-1:0]   exp10a_o,
  output logic [EXP_W-1:0]   exp10b_o,
  output logic [FRACT_W-1:0] fract24a_o,
  output logic [FRACT_W-1:0] fract24b_o,
  output logic               snana_o,
  output logic               snanb_o,
  output logic               qnana_o,
  output logic               qnanb_o,
  output logic               infa_o,
  output logic               infb_o,
  output logic               zeroa_o,
  output logic               zerob_o,
  output logic [NLZ_W-1:0]   nlza_o,
  output logic [NLZ_W-1:0]   nlzb_o,
  output logic [EXP_W-1:0]   exp10na_o,
  output logic [EXP_W-1:0]   exp10nb_o,
  output logic [FRACT_W-1:0] fract24na_o,
  output logic [FRACT_W-1:0] fract24nb_o
);

  pfpu32_unpacked_t opa_p1, opb_p1, opa_p2, opb_p2;
  logic [TAG_W-1:0] tag_p1, tag_p2;
  logic             vld_p1, vld_p2;
  logic             s1_adv, s2_adv;
  logic [NLZ_W-1:0] nlz_a_raw, nlz_b_raw, nlz_a, nlz_b;

  // exp10n is a signed quantity that may go negative; it wraps mod 2^EXP_W.
  function automatic pfpu32_unpacked_t normalize(input pfpu32_unpacked_t u,
                                                 input logic [NLZ_W-1:0] nlz);
    pfpu32_unpacked_t        r;
    logic signed [EXP_W-1:0] exp_s;
    exp_s      = $signed(u.exp10) - $signed({{(EXP_W-NLZ_W){1'b0}}, nlz});
    r          = u;
    r.nlz      = nlz;
    r.exp10n   = $unsigned(exp_s);
    r.fract24n = u.fract24 << nlz;
    return r;
  endfunction

  assign s2_adv  = !vld_p2 || ready_i;
  assign s1_adv  = !vld_p1 || s2_adv;
  assign ready_o = s1_adv;
  assign valid_o = vld_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (s1_adv) vld_p1 <= valid_i;
      if (s2_adv) vld_p2 <= vld_p1;
    end
  end

  // Stage 1: decode and classify on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_p1 <= '0;
      opb_p1 <= '0;
      tag_p1 <= '0;
    end else if (valid_i && s1_adv) begin
      opa_p1 <= pfpu32_decode(opa_i);
      opb_p1 <= pfpu32_decode(opb_i);
      tag_p1 <= tag_i;
    end
  end

  pfpu32_nlz24 u_nlz_a (.fract24(opa_p1.fract24), .nlz(nlz_a_raw));
  pfpu32_nlz24 u_nlz_b (.fract24(opb_p1.fract24), .nlz(nlz_b_raw));

  assign nlz_a = (NORM_EN != 0) ? nlz_a_raw : '0;
  assign nlz_b = (NORM_EN != 0) ? nlz_b_raw : '0;

  // Stage 2: leading-zero normalization
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_p2 <= '0;
      opb_p2 <= '0;
      tag_p2 <= '0;
    end else if (vld_p1 && s2_adv) begin
      opa_p2 <= normalize(opa_p1, nlz_a);
      opb_p2 <= normalize(opb_p1, nlz_b);
      tag_p2 <= tag_p1;
    end
  end

  assign tag_o       = tag_p2;
  assign signa_o     = opa_p2.sign;
  assign signb_o     = opb_p2.sign;
  assign exp10a_o    = opa_p2.exp10;
  assign exp10b_o    = opb_p2.exp10;
  assign fract24a_o  = opa_p2.fract24;
  assign fract24b_o  = opb_p2.fract24;
  assign snana_o     = opa_p2.snan;
  assign snanb_o     = opb_p2.snan;
  assign qnana_o     = opa_p2.qnan;
  assign qnanb_o     = opb_p2.qnan;
  assign infa_o      = opa_p2.inf;
  assign infb_o      = opb_p2.inf;
  assign zeroa_o     = opa_p2.zero;
  assign zerob_o     = opb_p2.zero;
  assign nlza_o      = opa_p2.nlz;
  assign nlzb_o      = opb_p2.nlz;
  assign exp10na_o   = opa_p2.exp10n;
  assign exp10nb_o   = opb_p2.exp10n;
  assign fract24na_o = opa_p2.fract24n;
  assign fract24nb_o = opb_p2.fract24n;

endmodule

// File: tb/tb_pfpu32_unpack.sv
// Directed bench for pfpu32_unpack: decode of normal/denormal/special operands,
// backpressure, flush and asynchronous reset behaviour.
module tb_pfpu32_unpack;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, valid_i, ready_i;
  logic        ready_o, valid_o;
  logic [31:0] opa_i, opb_i;
  logic [7:0]  tag_i, tag_o;
  logic        signa_o, signb_o;
  logic [9:0]  exp10a_o, exp10b_o, exp10na_o, exp10nb_o;
  logic [23:0] fract24a_o, fract24b_o, fract24na_o, fract24nb_o;
  logic        snana_o, snanb_o, qnana_o, qnanb_o, infa_o, infb_o, zeroa_o, zerob_o;
  logic [4:0]  nlza_o, nlzb_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pfpu32_unpack dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .opa_i(opa_i), .opb_i(opb_i), .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
    .tag_o(tag_o), .signa_o(signa_o), .signb_o(signb_o),
    .exp10a_o(exp10a_o), .exp10b_o(exp10b_o), .fract24a_o(fract24a_o), .fract24b_o(fract24b_o),
    .snana_o(snana_o), .snanb_o(snanb_o), .qnana_o(qnana_o), .qnanb_o(qnanb_o),
    .infa_o(infa_o), .infb_o(infb_o), .zeroa_o(zeroa_o), .zerob_o(zerob_o),
    .nlza_o(nlza_o), .nlzb_o(nlzb_o), .exp10na_o(exp10na_o), .exp10nb_o(exp10nb_o),
    .fract24na_o(fract24na_o), .fract24nb_o(fract24nb_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [7:0] t);
    valid_i = 1'b1;
    opa_i   = a;
    opb_i   = b;
    tag_i   = t;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    opa_i = '0; opb_i = '0; tag_i = '0;
    step(); step();
    chk("rst_valid_o", valid_o, 0);
    chk("rst_ready_o", ready_o, 1);
    chk("rst_tag_o", tag_o, 0);
    chk("rst_exp10a", exp10a_o, 0);
    chk("rst_fract24b", fract24b_o, 0);
    chk("rst_flags", {snana_o, qnana_o, infa_o, zeroa_o, snanb_o, qnanb_o, infb_o, zerob_o}, 0);
    rst_n = 1'b1;
    step();

    // Normal operands: 1.0 and -2.0
    drive(32'h3F800000, 32'hC0000000, 8'h11);
    step();
    valid_i = 1'b0;
    chk("norm_lat1_valid", valid_o, 0);
    step();
    chk("norm_valid", valid_o, 1);
    chk("norm_tag", tag_o, 8'h11);
    chk("norm_signa", signa_o, 0);
    chk("norm_exp10a", exp10a_o, 127);
    chk("norm_fract24a", fract24a_o, 24'h800000);
    chk("norm_signb", signb_o, 1);
    chk("norm_exp10b", exp10b_o, 128);
    chk("norm_fract24b", fract24b_o, 24'h800000);
    chk("norm_flags", {snana_o, qnana_o, infa_o, zeroa_o, snanb_o, qnanb_o, infb_o, zerob_o}, 0);
    chk("norm_nlz", {nlza_o, nlzb_o}, 0);
    chk("norm_exp10na", exp10na_o, 127);
    chk("norm_fract24nb", fract24nb_o, 24'h800000);
    step();
    chk("norm_drain_valid", valid_o, 0);

    // Back-to-back stream: denormal, specials, mid denormals
    drive(32'h00000001, 32'h00000000, 8'h12);
    step();
    drive(32'h7FC00000, 32'h7F800001, 8'h13);
    step();
    chk("dn_tag", tag_o, 8'h12);
    chk("dn_exp10a", exp10a_o, 1);
    chk("dn_fract24a", fract24a_o, 24'h000001);
    chk("dn_nlza", nlza_o, 23);
    chk("dn_fract24na", fract24na_o, 24'h800000);
    chk("dn_exp10na", exp10na_o, 10'h3EA);
    chk("dn_zeroa", zeroa_o, 0);
    chk("dn_zerob", zerob_o, 1);
    chk("dn_b_norm", {nlzb_o, exp10nb_o, fract24nb_o}, 0);
    drive(32'hFF800000, 32'h80000000, 8'h14);
    step();
    chk("sp1_tag", tag_o, 8'h13);
    chk("sp1_flags_a", {snana_o, qnana_o, infa_o, zeroa_o}, 4'b0100);
    chk("sp1_flags_b", {snanb_o, qnanb_o, infb_o, zerob_o}, 4'b1000);
    chk("sp1_exp10a", exp10a_o, 10'h0FF);
    chk("sp1_fract24a", fract24a_o, 24'hC00000);
    chk("sp1_fract24b", fract24b_o, 24'h800001);
    drive(32'h00400000, 32'h00000003, 8'h15);
    step();
    valid_i = 1'b0;
    chk("sp2_tag", tag_o, 8'h14);
    chk("sp2_flags_a", {signa_o, snana_o, qnana_o, infa_o, zeroa_o}, 5'b10010);
    chk("sp2_flags_b", {signb_o, snanb_o, qnanb_o, infb_o, zerob_o}, 5'b10001);
    chk("sp2_exp10a", exp10a_o, 10'h0FF);
    chk("sp2_nlzb", nlzb_o, 0);
    step();
    chk("mid_tag", tag_o, 8'h15);
    chk("mid_nlza", nlza_o, 1);
    chk("mid_exp10na", exp10na_o, 0);
    chk("mid_fract24na", fract24na_o, 24'h800000);
    chk("mid_nlzb", nlzb_o, 22);
    chk("mid_exp10nb", exp10nb_o, 10'h3EB);
    chk("mid_fract24nb", fract24nb_o, 24'hC00000);
    step();
    chk("mid_drain_valid", valid_o, 0);

    // Backpressure: three ops, ready_i low for four cycles
    ready_i = 1'b0;
    drive(32'h3F800000, 32'h0, 8'h01);
    chk("bp_ready_op1", ready_o, 1);
    step();
    drive(32'h40000000, 32'h0, 8'h02);
    chk("bp_ready_op2", ready_o, 1);
    step();
    drive(32'h40400000, 32'h0, 8'h03);
    chk("bp_ready_full", ready_o, 0);
    chk("bp_hold0_tag", tag_o, 8'h01);
    step();
    chk("bp_hold1_valid", valid_o, 1);
    chk("bp_hold1_tag", tag_o, 8'h01);
    chk("bp_hold1_exp10a", exp10a_o, 127);
    chk("bp_hold1_ready", ready_o, 0);
    step();
    chk("bp_hold2_tag", tag_o, 8'h01);
    chk("bp_hold2_fract24a", fract24a_o, 24'h800000);
    chk("bp_hold2_ready", ready_o, 0);
    ready_i = 1'b1;
    #1;
    chk("bp_ready_release", ready_o, 1);
    step();
    valid_i = 1'b0;
    chk("bp_out2_valid", valid_o, 1);
    chk("bp_out2_tag", tag_o, 8'h02);
    chk("bp_out2_exp10a", exp10a_o, 128);
    step();
    chk("bp_out3_tag", tag_o, 8'h03);
    chk("bp_out3_fract24a", fract24a_o, 24'hC00000);
    step();
    chk("bp_drain_valid", valid_o, 0);

    // Flush with two ops held and a third presented
    ready_i = 1'b0;
    drive(32'h3F800000, 32'h0, 8'h21);
    step();
    drive(32'h40000000, 32'h0, 8'h22);
    step();
    drive(32'h40400000, 32'h0, 8'h23);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("fl_valid_next", valid_o, 0);
    chk("fl_ready_next", ready_o, 1);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_valid_after", valid_o, 0);
    end

    // Op accepted in the flush cycle is dropped; ready_o not gated by flush
    drive(32'h3F800000, 32'h0, 8'h24);
    flush_i = 1'b1;
    #1;
    chk("fl_ready_ungated", ready_o, 1);
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_drop_valid", valid_o, 0);
    end

    // Asynchronous reset with both stages full
    ready_i = 1'b0;
    drive(32'h3F800000, 32'hC0000000, 8'h31);
    step();
    drive(32'h40000000, 32'h0, 8'h32);
    step();
    valid_i = 1'b0;
    chk("rm_full_valid", valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_valid_o", valid_o, 0);
    chk("rm_tag_o", tag_o, 0);
    chk("rm_exp10a", exp10a_o, 0);
    chk("rm_signb", signb_o, 0);
    chk("rm_fract24na", fract24na_o, 0);
    step();
    rst_n = 1'b1;
    ready_i = 1'b1;
    #1;
    chk("rm_ready_after", ready_o, 1);
    step();
    chk("rm_valid_after", valid_o, 0);
    step();
    chk("rm_valid_after2", valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
